// File: rtl/oob_ctrl.sv
// oob_ctrl: link-level sequencer in front of the SATA OOB unit.
// Waits for transceiver readiness, launches host OOB, arbitrates device
// COMINIT, retries failures after a backoff delay and restarts OOB when the
// link is lost for longer than the glitch filter.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RESET_WAIT | waiting for gtx_ready
// IDLE       | ready; answer device COMINIT or launch host OOB when not busy
// START      | one-cycle oob_start pulse
// WAIT_OOB   | OOB running; watchdog counting, waiting for done/failure
// BACKOFF    | delay between a failed/lost attempt and the next start
// LINK       | link up, phy_ready asserted, link_down filtered
// FAIL       | retries exhausted; parked until link_reset or rst
module oob_ctrl #(
  parameter logic [15:0] RETRY_DELAY     = 16'd1000,
  parameter logic [3:0]  MAX_RETRIES     = 4'd8,
  parameter logic [7:0]  LINKDOWN_FILTER = 8'd32,
  parameter logic [19:0] WAIT_TIMEOUT    = 20'd600000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gtx_ready,
  input  logic       link_reset,
  output logic       oob_start,
  input  logic       oob_busy,
  input  logic       oob_done,
  input  logic       oob_error,
  input  logic       oob_silence,
  input  logic       oob_incompatible,
  input  logic       link_down,
  input  logic       cominit_req,
  output logic       cominit_allow,
  output logic       phy_ready,
  output logic       ctrl_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] err_silence_cnt,
  output logic [7:0] err_incompat_cnt
);

  localparam logic [2:0] S_RESET_WAIT = 3'd0;
  localparam logic [2:0] S_IDLE       = 3'd1;
  localparam logic [2:0] S_START      = 3'd2;
  localparam logic [2:0] S_WAIT_OOB   = 3'd3;
  localparam logic [2:0] S_BACKOFF    = 3'd4;
  localparam logic [2:0] S_LINK       = 3'd5;
  localparam logic [2:0] S_FAIL       = 3'd6;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [19:0] wd_cnt;
  logic [15:0] bo_cnt;
  logic [7:0]  ld_cnt;
  logic [3:0]  retry_inc;
  logic        gtx_lost;
  logic        wd_expired;
  logic        fail_evt;
  logic        ld_trip;
  logic        cominit_take;
  logic        wait_active;

  // gtx_ready dropping only matters once the sequence has left RESET_WAIT;
  // FAIL stays parked regardless so software sees the failure.
  assign gtx_lost   = !gtx_ready && (state != S_RESET_WAIT) && (state != S_FAIL);
  assign wd_expired = (wd_cnt == WAIT_TIMEOUT);
  assign fail_evt   = oob_incompatible | oob_silence | oob_error | wd_expired;
  assign ld_trip    = link_down && (ld_cnt == LINKDOWN_FILTER - 8'd1);
  assign retry_inc  = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
  // WAIT_OOB events only count when nothing with higher priority is pending
  assign wait_active = (state == S_WAIT_OOB) && !rst && !link_reset && !gtx_lost;

  // next-state selection; link_reset and gtx loss override every local event
  always_comb begin
    state_nxt    = state;
    cominit_take = 1'b0;
    if (rst || link_reset || gtx_lost) begin
      state_nxt = S_RESET_WAIT;
    end else begin
      case (state)
        S_RESET_WAIT: if (gtx_ready) state_nxt = S_IDLE;
        S_IDLE: begin
          if (cominit_req) begin
            cominit_take = 1'b1;
            state_nxt    = S_WAIT_OOB;
          end else if (!oob_busy) begin
            state_nxt = S_START;
          end
        end
        S_START: state_nxt = S_WAIT_OOB;
        S_WAIT_OOB: begin
          if (oob_done)      state_nxt = S_LINK;
          else if (fail_evt) state_nxt = (retry_inc >= MAX_RETRIES) ? S_FAIL : S_BACKOFF;
        end
        S_BACKOFF: begin
          if (cominit_req) begin
            cominit_take = 1'b1;
            state_nxt    = S_WAIT_OOB;
          end else if (bo_cnt == RETRY_DELAY - 16'd1) begin
            state_nxt = S_START;
          end
        end
        S_LINK: begin
          if (cominit_req) begin
            cominit_take = 1'b1;
            state_nxt    = S_WAIT_OOB;
          end else if (ld_trip) begin
            state_nxt = S_BACKOFF;
          end
        end
        S_FAIL:  state_nxt = S_FAIL;
        default: state_nxt = S_RESET_WAIT;
      endcase
    end
  end

  assign oob_start     = (state == S_START);
  assign cominit_allow = cominit_take;
  assign phy_ready     = (state == S_LINK);
  assign ctrl_fail     = (state == S_FAIL);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET_WAIT;
    else     state <= state_nxt;
  end

  // per-state timers; each one restarts from zero whenever its state is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      bo_cnt <= '0;
      ld_cnt <= '0;
    end else begin
      wd_cnt <= (state == S_WAIT_OOB) ? wd_cnt + 20'd1 : 20'd0;
      bo_cnt <= (state == S_BACKOFF) ? bo_cnt + 16'd1 : 16'd0;
      ld_cnt <= (state == S_LINK && link_down) ? ld_cnt + 8'd1 : 8'd0;
    end
  end

  // retry and error bookkeeping; error counters survive link_reset
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt        <= '0;
      err_silence_cnt  <= '0;
      err_incompat_cnt <= '0;
    end else begin
      if (link_reset) begin
        retry_cnt <= '0;
      end else if (wait_active) begin
        if (oob_done)      retry_cnt <= '0;
        else if (fail_evt) retry_cnt <= retry_inc;
      end
      if (wait_active && !oob_done) begin
        if (oob_incompatible) begin
          if (err_incompat_cnt != 8'hFF) err_incompat_cnt <= err_incompat_cnt + 8'd1;
        end else if (oob_silence) begin
          if (err_silence_cnt != 8'hFF) err_silence_cnt <= err_silence_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_oob_ctrl.sv
// tb_oob_ctrl: directed scenarios plus random traffic, every cycle compared
// against a timestamp-based behavioural model of the sequencer.
module tb_oob_ctrl;

  localparam int RD = 50;
  localparam int MR = 3;
  localparam int LF = 32;
  localparam int WT = 300;

  localparam int P_RW = 0, P_IDLE = 1, P_START = 2, P_WAIT = 3, P_BACK = 4, P_LINK = 5, P_FAIL = 6;

  logic clk = 1'b0;
  logic rst, gtx_ready, link_reset, oob_busy, oob_done, oob_error, oob_silence;
  logic oob_incompatible, link_down, cominit_req;
  logic oob_start, cominit_allow, phy_ready, ctrl_fail;
  logic [3:0] retry_cnt;
  logic [7:0] err_silence_cnt, err_incompat_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int last_start = -1;
  bit armed = 1'b0;

  // behavioural model: phase plus entry timestamps instead of counters
  int m_ph = P_RW;
  int m_retry = 0, m_sil = 0, m_inc = 0;
  int m_wait_entry = 0, m_back_entry = 0, m_run = 0;

  oob_ctrl #(
    .RETRY_DELAY(16'd50), .MAX_RETRIES(4'd3), .LINKDOWN_FILTER(8'd32), .WAIT_TIMEOUT(20'd300)
  ) dut (
    .clk(clk), .rst(rst), .gtx_ready(gtx_ready), .link_reset(link_reset),
    .oob_start(oob_start), .oob_busy(oob_busy), .oob_done(oob_done),
    .oob_error(oob_error), .oob_silence(oob_silence),
    .oob_incompatible(oob_incompatible), .link_down(link_down),
    .cominit_req(cominit_req), .cominit_allow(cominit_allow),
    .phy_ready(phy_ready), .ctrl_fail(ctrl_fail), .retry_cnt(retry_cnt),
    .err_silence_cnt(err_silence_cnt), .err_incompat_cnt(err_incompat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_ph = P_RW; m_retry = 0; m_sil = 0; m_inc = 0;
    end else if (link_reset) begin
      m_ph = P_RW; m_retry = 0;
    end else if (!gtx_ready && m_ph != P_RW && m_ph != P_FAIL) begin
      m_ph = P_RW;
    end else begin
      case (m_ph)
        P_RW:    if (gtx_ready) m_ph = P_IDLE;
        P_IDLE:  if (cominit_req) begin m_ph = P_WAIT; m_wait_entry = cyc + 1; end
                 else if (!oob_busy) m_ph = P_START;
        P_START: begin m_ph = P_WAIT; m_wait_entry = cyc + 1; end
        P_WAIT: begin
          if (oob_done) begin
            m_ph = P_LINK; m_retry = 0; m_run = 0;
          end else if (oob_incompatible || oob_silence || oob_error || (cyc - m_wait_entry == WT)) begin
            if (oob_incompatible) m_inc = sat(m_inc, 255);
            else if (oob_silence) m_sil = sat(m_sil, 255);
            m_retry = sat(m_retry, 15);
            if (m_retry >= MR) m_ph = P_FAIL;
            else begin m_ph = P_BACK; m_back_entry = cyc + 1; end
          end
        end
        P_BACK: begin
          if (cominit_req) begin m_ph = P_WAIT; m_wait_entry = cyc + 1; end
          else if (cyc - m_back_entry == RD - 1) m_ph = P_START;
        end
        P_LINK: begin
          if (cominit_req) begin
            m_ph = P_WAIT; m_wait_entry = cyc + 1;
          end else if (link_down) begin
            m_run++;
            if (m_run == LF) begin m_ph = P_BACK; m_back_entry = cyc + 1; end
          end else begin
            m_run = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  // one clock: compare outputs mid-cycle, advance model at posedge, return at negedge
  task automatic tick();
    bit exp_allow;
    #2;
    if (armed) begin
      exp_allow = !rst && !link_reset && gtx_ready && cominit_req &&
                  (m_ph == P_IDLE || m_ph == P_BACK || m_ph == P_LINK);
      chk("oob_start", oob_start, m_ph == P_START);
      chk("cominit_allow", cominit_allow, exp_allow);
      chk("phy_ready", phy_ready, m_ph == P_LINK);
      chk("ctrl_fail", ctrl_fail, m_ph == P_FAIL);
      chk("retry_cnt", retry_cnt, m_retry);
      chk("err_silence_cnt", err_silence_cnt, m_sil);
      chk("err_incompat_cnt", err_incompat_cnt, m_inc);
    end
    if (oob_start === 1'b1) begin n_start++; last_start = cyc; end
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    armed = 1'b1;
  endtask

  task automatic wait_start(input int max);
    int n0 = n_start;
    int i = 0;
    while (n_start == n0 && i < max) begin tick(); i++; end
    chk("start_seen", n_start - n0, 1);
  endtask

  initial begin
    int n0, t, t0, ld_left, gtx_hold;
    int st[3];
    rst = 1; gtx_ready = 0; link_reset = 0; oob_busy = 0; oob_done = 0; oob_error = 0;
    oob_silence = 0; oob_incompatible = 0; link_down = 0; cominit_req = 0;
    @(negedge clk);

    // reset state and first-attempt latency
    tick(); tick(); rst = 0; cyc = 0;
    chk("rst_oob_start", oob_start, 0);
    chk("rst_phy_ready", phy_ready, 0);
    chk("rst_ctrl_fail", ctrl_fail, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_err_sil", err_silence_cnt, 0);
    chk("rst_err_inc", err_incompat_cnt, 0);
    while (cyc < 10) tick();
    gtx_ready = 1; n0 = n_start;
    wait_start(20);
    chk("start_cycle", last_start, 12);
    while (cyc < last_start + 200) tick();
    oob_done = 1; tick(); oob_done = 0;
    chk("phy_after_done", phy_ready, 1);
    chk("retry_after_done", retry_cnt, 0);
    chk("single_start", n_start - n0, 1);

    // link_down filter: 31-cycle glitch ignored, 32 cycles trips
    link_down = 1; repeat (31) tick(); link_down = 0; tick();
    chk("glitch_ignored", phy_ready, 1);
    repeat (5) tick();
    link_down = 1; repeat (31) tick();
    chk("phy_before_trip", phy_ready, 1);
    t = cyc; tick(); link_down = 0;
    chk("phy_after_trip", phy_ready, 0);
    chk("retry_after_trip", retry_cnt, 0);
    wait_start(200);
    chk("restart_delay", last_start - t, RD + 1);
    oob_done = 1; tick(); oob_done = 0;
    chk("relink", phy_ready, 1);

    // cominit_req wins over a host start in IDLE
    link_reset = 1; tick(); link_reset = 0;
    tick();
    cominit_req = 1; #1;
    chk("allow_in_idle", cominit_allow, 1);
    chk("no_start_idle", oob_start, 0);
    tick(); cominit_req = 0; n0 = n_start; #1;
    chk("allow_one_cycle", cominit_allow, 0);
    repeat (10) tick();
    chk("no_start_after_cominit", n_start - n0, 0);
    oob_done = 1; tick(); oob_done = 0;
    chk("phy_after_dev_oob", phy_ready, 1);

    // incompatible failure, then oob_done colliding with link_reset
    cominit_req = 1; tick(); cominit_req = 0;
    oob_incompatible = 1; tick(); oob_incompatible = 0;
    chk("inc_count", err_incompat_cnt, 1);
    chk("retry_one", retry_cnt, 1);
    wait_start(100);
    oob_done = 1; link_reset = 1; tick(); oob_done = 0; link_reset = 0;
    chk("phy_done_vs_reset", phy_ready, 0);
    chk("retry_cleared", retry_cnt, 0);
    chk("inc_kept", err_incompat_cnt, 1);
    chk("sil_kept", err_silence_cnt, 0);
    t0 = cyc;
    wait_start(10);
    chk("reset_wait_restart", last_start - t0, 2);
    oob_done = 1; tick(); oob_done = 0;

    // silence retries exhaust MAX_RETRIES
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 3; k++) begin
      wait_start(200); st[k] = last_start;
      oob_silence = 1; tick(); oob_silence = 0;
    end
    chk("spacing_1", st[1] - st[0], RD + 2);
    chk("spacing_2", st[2] - st[1], RD + 2);
    chk("fail_level", ctrl_fail, 1);
    chk("fail_retry", retry_cnt, 3);
    chk("fail_sil", err_silence_cnt, 3);
    n0 = n_start;
    repeat (1000) tick();
    chk("no_start_in_fail", n_start - n0, 0);
    link_reset = 1; tick(); link_reset = 0;
    chk("fail_cleared", ctrl_fail, 0);

    // watchdog timeout with oob_busy stuck
    rst = 1; tick(); rst = 0;
    wait_start(20); t = last_start; oob_busy = 1;
    wait_start(WT + RD + 20);
    chk("timeout_restart", last_start - t, WT + RD + 2);
    chk("timeout_retry", retry_cnt, 1);
    chk("timeout_sil", err_silence_cnt, 0);
    chk("timeout_inc", err_incompat_cnt, 0);
    oob_busy = 0;

    // random traffic
    ld_left = 0; gtx_hold = 0;
    for (int i = 0; i < 8000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      link_reset = ($urandom_range(0, 399) == 0);
      if (gtx_hold > 0) begin gtx_hold--; gtx_ready = 0; end
      else begin gtx_ready = 1; if ($urandom_range(0, 599) == 0) gtx_hold = $urandom_range(1, 8); end
      oob_busy = ($urandom_range(0, 3) == 0);
      oob_done = ($urandom_range(0, 59) == 0);
      oob_incompatible = ($urandom_range(0, 149) == 0);
      oob_silence = ($urandom_range(0, 149) == 0);
      oob_error = ($urandom_range(0, 149) == 0);
      cominit_req = ($urandom_range(0, 119) == 0);
      if (ld_left == 0) begin
        link_down = ~link_down;
        ld_left = link_down ? $urandom_range(1, 45) : $urandom_range(1, 60);
      end
      ld_left--;
      tick();
    end
    rst = 0; link_reset = 0; gtx_ready = 1; oob_busy = 0; oob_done = 0; oob_error = 0;
    oob_silence = 0; oob_incompatible = 0; link_down = 0; cominit_req = 0;

    // drive both error counters into saturation
    link_reset = 1; tick(); link_reset = 0;
    for (int k = 0; k < 520; k++) begin
      wait_start(200);
      if (k % 2 == 1) oob_incompatible = 1; else oob_silence = 1;
      tick(); oob_incompatible = 0; oob_silence = 0;
      if (m_ph == P_FAIL) begin link_reset = 1; tick(); link_reset = 0; end
    end
    chk("sil_saturated", err_silence_cnt, 255);
    chk("inc_saturated", err_incompat_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
